// File: rtl/vx_dot_pkg.sv
// vx_dot_pkg: shared mode encoding, element helpers and lane payload for the dot-product PE
package vx_dot_pkg;

    localparam int MAX_ELEMS = 8;

    typedef enum logic [1:0] {
        DOT_MODE_8   = 2'd0,
        DOT_MODE_16  = 2'd1,
        DOT_MODE_4   = 2'd2,
        DOT_MODE_RSV = 2'd3
    } dot_mode_e;

    // Products are kept already truncated to 32 bits: the final result wraps mod 2^32,
    // so dropping the upper product bits early changes nothing.
    typedef struct packed {
        logic [MAX_ELEMS-1:0][31:0] prod;
        logic [31:0]                c;
    } dot_lane_t;

    function automatic int unsigned dot_width(dot_mode_e m);
        return (m == DOT_MODE_16) ? 16 : (m == DOT_MODE_4) ? 4 : 8;
    endfunction

    function automatic int unsigned dot_elems(dot_mode_e m);
        return (m == DOT_MODE_RSV) ? 0 : 32 / dot_width(m);
    endfunction

    // Element i of a word, extended to 32 bits; zero beyond the element count or in the reserved mode.
    function automatic logic [31:0] dot_elem(logic [31:0] w, int unsigned i, dot_mode_e m, logic sgn);
        logic [31:0] s;
        if (i >= dot_elems(m)) return '0;
        s = w >> (i * dot_width(m));
        case (m)
            DOT_MODE_16: return sgn ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
            DOT_MODE_4:  return sgn ? {{28{s[3]}}, s[3:0]} : {28'b0, s[3:0]};
            default:     return sgn ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
        endcase
    endfunction

endpackage

// File: rtl/vx_dot_lane.sv
// vx_dot_lane: combinational single-lane element multiply and product reduction
module vx_dot_lane
    import vx_dot_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  dot_mode_e   mode_i,
    input  logic        sgn_i,
    input  logic        acc_i,
    output dot_lane_t   mul_o,
    input  dot_lane_t   red_i,
    output logic [31:0] sum_o
);

    // Per-element products; accumulator is zeroed when unused or in the reserved mode
    always_comb begin
        for (int i = 0; i < MAX_ELEMS; i++)
            mul_o.prod[i] = dot_elem(a_i, i, mode_i, sgn_i) * dot_elem(b_i, i, mode_i, sgn_i);
        mul_o.c = (acc_i && mode_i != DOT_MODE_RSV) ? c_i : '0;
    end

    // Reduction of a (possibly registered) product set plus accumulator, wrapping at 32 bits
    always_comb begin
        sum_o = red_i.c;
        for (int i = 0; i < MAX_ELEMS; i++)
            sum_o = sum_o + red_i.prod[i];
    end

endmodule

// File: rtl/vx_alu_dotn.sv
// vx_alu_dotn: pipelined packed-integer dot-product PE with valid/ready backpressure
module vx_alu_dotn
    import vx_dot_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TAG_W     = 16,
    parameter int LATENCY   = 2,
    parameter int PERF_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [1:0]              in_mode,
    input  logic                    in_signed,
    input  logic                    in_acc,
    input  logic [NUM_LANES*32-1:0] in_a,
    input  logic [NUM_LANES*32-1:0] in_b,
    input  logic [NUM_LANES*32-1:0] in_c,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TAG_W-1:0]        out_tag,
    output logic [NUM_LANES*32-1:0] out_data,
    output logic [2:0]              inflight,
    output logic [PERF_W-1:0]       perf_ops
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("vx_alu_dotn: LATENCY must be in 1..4");
    end

    // Stage index whose register holds the reduced sum (S1 when the pipe is one deep)
    localparam int RS = (LATENCY == 1) ? 0 : 1;

    logic [LATENCY-1:0]          v_q;
    logic [LATENCY-1:0]          rdy;
    logic [TAG_W-1:0]            tag_q [LATENCY];
    dot_lane_t [NUM_LANES-1:0]   mul_d;
    dot_lane_t [NUM_LANES-1:0]   red_src;
    logic [NUM_LANES-1:0][31:0]  red_d;
    logic [NUM_LANES-1:0][31:0]  dat_q [RS:LATENCY-1];
    logic [PERF_W-1:0]           perf_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vx_dot_lane u_lane (
            .a_i    (in_a[l*32 +: 32]),
            .b_i    (in_b[l*32 +: 32]),
            .c_i    (in_c[l*32 +: 32]),
            .mode_i (dot_mode_e'(in_mode)),
            .sgn_i  (in_signed),
            .acc_i  (in_acc),
            .mul_o  (mul_d[l]),
            .red_i  (red_src[l]),
            .sum_o  (red_d[l])
        );
    end

    if (LATENCY == 1) begin : g_fold
        assign red_src = mul_d;
    end else begin : g_split
        dot_lane_t [NUM_LANES-1:0] p_q;
        assign red_src = p_q;
        // S1 captures the per-element products
        always_ff @(posedge clk or negedge reset)
            if (!reset) p_q <= '0;
            else if (rdy[0]) p_q <= mul_d;
    end

    // A stage may load when it or any stage below it is empty, or the consumer takes the output
    always_comb begin
        for (int k = 0; k < LATENCY; k++) begin
            rdy[k] = out_ready;
            for (int j = k; j < LATENCY; j++) rdy[k] = rdy[k] || !v_q[j];
        end
    end

    // Valid and tag shift register; each stage advances independently so bubbles collapse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
            for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
        end else begin
            if (rdy[0]) begin
                v_q[0]   <= in_valid;
                tag_q[0] <= in_tag;
            end
            for (int k = 1; k < LATENCY; k++)
                if (rdy[k]) begin
                    v_q[k]   <= v_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
        end
    end

    // Reduced sum enters at the reduce stage; later stages are pure delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = RS; k < LATENCY; k++) dat_q[k] <= '0;
        end else begin
            if (rdy[RS]) dat_q[RS] <= red_d;
            for (int k = RS + 1; k < LATENCY; k++)
                if (rdy[k]) dat_q[k] <= dat_q[k-1];
        end
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk or negedge reset)
        if (!reset) perf_q <= '0;
        else if (out_valid && out_ready) perf_q <= perf_q + 1'b1;

    assign in_ready  = rdy[0];
    assign out_valid = v_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];
    assign inflight  = 3'($countones(v_q));
    assign perf_ops  = perf_q;

    a_in_hold: assert property (@(posedge clk) disable iff (!reset)
        in_valid && !in_ready |=> in_valid && $stable({in_tag, in_mode, in_signed, in_acc, in_a, in_b, in_c}));

endmodule

// File: tb/tb_vx_alu_dotn.sv
// tb_vx_alu_dotn: directed self-checking bench for the dot-product PE (LATENCY 2 and 3 instances)
module tb_vx_alu_dotn;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_signed, in_acc, out_valid, out_ready;
    logic [15:0]  in_tag, out_tag;
    logic [1:0]   in_mode;
    logic [127:0] in_a, in_b, in_c, out_data;
    logic [2:0]   inflight;
    logic [31:0]  perf_ops;

    logic         in_valid3, in_ready3, out_valid3, out_ready3;
    logic [15:0]  in_tag3, out_tag3;
    logic [127:0] in_a3, out_data3;
    logic [2:0]   inflight3;
    logic [31:0]  perf_ops3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vx_alu_dotn u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_mode(in_mode), .in_signed(in_signed), .in_acc(in_acc), .in_a(in_a), .in_b(in_b),
        .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_data(out_data), .inflight(inflight), .perf_ops(perf_ops)
    );

    vx_alu_dotn #(.LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3), .in_tag(in_tag3),
        .in_mode(in_mode), .in_signed(in_signed), .in_acc(in_acc), .in_a(in_a3), .in_b(in_b),
        .in_c(in_c), .out_valid(out_valid3), .out_ready(out_ready3), .out_tag(out_tag3),
        .out_data(out_data3), .inflight(inflight3), .perf_ops(perf_ops3)
    );

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [15:0] t);
        return {4{{16'b0, t}}};
    endfunction

    // One request through the LATENCY=2 instance with out_ready held high
    task automatic run_op(input string nm, input logic [15:0] tg, input logic [1:0] md, input logic sg,
                          input logic ac, input logic [127:0] a, input logic [127:0] b,
                          input logic [127:0] c, input logic [127:0] exp);
        in_tag = tg; in_mode = md; in_signed = sg; in_acc = ac;
        in_a = a; in_b = b; in_c = c; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({nm, " in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, " early_valid"}, out_valid, 1'b0);
        @(posedge clk); #1;
        chk({nm, " out_valid"}, out_valid, 1'b1);
        chk({nm, " out_tag"}, out_tag, tg);
        chk({nm, " out_data"}, out_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0]  nxt, exp_t;
        logic         stalled;
        logic [143:0] held;
        int           exp_if [5] = '{0, 1, 2, 3, 3};
        logic         exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic         exp_ov [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        reset = 1'b0;
        in_valid = 1'b0; in_tag = '0; in_mode = '0; in_signed = 1'b0; in_acc = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b0;
        in_valid3 = 1'b0; in_tag3 = '0; in_a3 = '0; out_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst inflight", inflight, 3'd0);
        chk("rst perf", perf_ops, 32'd0);
        chk("rst out_data", out_data, '0);
        chk("rst out_tag", out_tag, 16'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst in_ready", in_ready, 1'b1);

        run_op("m0s_small", 16'd1, 2'd0, 1'b1, 1'b0, {4{32'h01020304}}, {4{32'h01010101}}, '0, {4{32'h0000000A}});
        run_op("m0s_neg", 16'd2, 2'd0, 1'b1, 1'b0, {4{32'hFFFFFFFF}}, {4{32'h02020202}}, '0, {4{32'hFFFFFFF8}});
        run_op("m0u_neg", 16'd3, 2'd0, 1'b0, 1'b0, {4{32'hFFFFFFFF}}, {4{32'h02020202}}, '0, {4{32'h000007F8}});
        run_op("m1s", 16'd4, 2'd1, 1'b1, 1'b0, {4{32'h80000001}}, {4{32'h00020003}}, '0, {4{32'hFFFF0003}});
        run_op("m1u_wrap", 16'd5, 2'd1, 1'b0, 1'b0, {4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}, '0, {4{32'hFFFC0002}});
        run_op("m2_acc", 16'd6, 2'd2, 1'b1, 1'b1, {4{32'h11111111}}, {4{32'h22222222}}, {4{32'd100}}, {4{32'd116}});
        run_op("m2_noacc", 16'd7, 2'd2, 1'b1, 1'b0, {4{32'h11111111}}, {4{32'h22222222}}, {4{32'd100}}, {4{32'd16}});
        run_op("m2s_neg", 16'd8, 2'd2, 1'b1, 1'b0, {4{32'hFFFFFFFF}}, {4{32'h77777777}}, '0, {4{32'hFFFFFFC8}});
        run_op("m2u_neg", 16'd9, 2'd2, 1'b0, 1'b0, {4{32'hFFFFFFFF}}, {4{32'h77777777}}, '0, {4{32'h00000348}});
        run_op("m3_rsv", 16'hBEEF, 2'd3, 1'b1, 1'b1, {4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}, {4{32'd100}}, '0);
        run_op("lanes", 16'd11, 2'd0, 1'b0, 1'b0,
               {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101}, {4{32'h01010101}}, '0,
               {32'd16, 32'd12, 32'd8, 32'd4});
        chk("perf after ops", perf_ops, 32'd11);

        // Backpressure stream: tags 1..10, out_ready 1 for 3 cycles, 0 for 5, then 1
        reset = 1'b0;
        #1;
        reset = 1'b1;
        in_mode = 2'd0; in_signed = 1'b0; in_acc = 1'b0; in_b = {4{32'h01010101}}; in_c = '0;
        nxt = 16'd1; exp_t = 16'd1; stalled = 1'b0; held = '0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && exp_t <= 16'd10; cyc++) begin
            out_ready = (cyc < 3 || cyc >= 8);
            in_valid = (nxt <= 16'd10); in_tag = nxt; in_a = mk(nxt);
            #1;
            if (out_ready) chk("bp in_ready open", in_ready, 1'b1);
            if (!out_ready && inflight == 3'd2) chk("bp in_ready full", in_ready, 1'b0);
            if (out_valid && !out_ready && stalled) chk("bp hold", {out_tag, out_data}, held);
            if (out_valid && out_ready) begin
                chk("bp tag order", out_tag, exp_t);
                chk("bp data", out_data, mk(exp_t));
                exp_t++;
            end
            stalled = out_valid && !out_ready;
            held = {out_tag, out_data};
            if (in_valid && in_ready) nxt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp all received", exp_t, 16'd11);
        chk("bp perf", perf_ops, 32'd10);

        // Reset with two requests in flight and the output stalled
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 16'hA1; in_a = mk(16'hA1);
        @(posedge clk); #1;
        in_tag = 16'hA2; in_a = mk(16'hA2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid inflight", inflight, 3'd2);
        chk("mid out_valid", out_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("async out_valid", out_valid, 1'b0);
        chk("async inflight", inflight, 3'd0);
        chk("async perf", perf_ops, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post rst in_ready", in_ready, 1'b1);
        chk("post rst no stale", out_valid, 1'b0);
        run_op("post_rst", 16'h55, 2'd0, 1'b1, 1'b0, {4{32'h01020304}}, {4{32'h01010101}}, '0, {4{32'h0000000A}});
        chk("post rst perf", perf_ops, 32'd1);

        // Bubble collapse on the LATENCY=3 instance with the output stalled
        in_mode = 2'd0; in_signed = 1'b0; in_acc = 1'b0; in_b = {4{32'h01010101}}; in_c = '0;
        out_ready3 = 1'b0; in_valid3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_tag3 = (i < 3) ? 16'(i + 1) : 16'd4;
            in_a3 = mk(in_tag3);
            #1;
            chk("l3 inflight", inflight3, 3'(exp_if[i]));
            chk("l3 in_ready", in_ready3, exp_rdy[i]);
            chk("l3 out_valid", out_valid3, exp_ov[i]);
            @(posedge clk); #1;
        end
        chk("l3 first tag", out_tag3, 16'd1);
        chk("l3 first data", out_data3, mk(16'd1));
        out_ready3 = 1'b1;
        #1;
        chk("l3 reopen", in_ready3, 1'b1);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        for (int t = 2; t <= 4; t++) begin
            chk("l3 drain valid", out_valid3, 1'b1);
            chk("l3 drain tag", out_tag3, 16'(t));
            chk("l3 drain data", out_data3, mk(16'(t)));
            @(posedge clk); #1;
        end
        chk("l3 empty", out_valid3, 1'b0);
        chk("l3 perf", perf_ops3, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
